// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM block: run state and
// derived-constant helpers used by the top and the channel slices.
package servo_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned UsPerSec = 1_000_000;

    function automatic int unsigned tick_div(input int unsigned clk_hz);
        return clk_hz / UsPerSec;
    endfunction

    function automatic int unsigned center_code(input int unsigned pos_w);
        return 32'd1 << (pos_w - 1);
    endfunction

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: target/current position registers, per-frame slew step,
// position-to-width mapping and the registered PWM comparator.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned POS_W   = 8,
    parameter int unsigned SLEW_W  = 8,
    parameter int unsigned FRAME_W = 15,
    parameter int unsigned MIN_US  = 1000,
    parameter int unsigned MAX_US  = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               boundary_i,
    input  logic               run_i,
    input  logic [FRAME_W-1:0] frame_us_i,
    input  logic [SLEW_W-1:0]  slew_step_i,
    input  logic [POS_W-1:0]   pos_i,
    input  logic               load_i,
    output logic               pwm_o,
    output logic               at_target_o
);

    localparam int unsigned Span     = MAX_US - MIN_US;
    localparam int unsigned ProdW    = POS_W + $clog2(Span + 1);
    localparam int unsigned DiffW    = POS_W + 1;
    localparam int unsigned MagW     = (DiffW > SLEW_W) ? DiffW : SLEW_W;
    localparam int unsigned CenterI  = center_code(POS_W);
    localparam int unsigned WidthCtr = MIN_US + ((CenterI * Span) >> POS_W);

    localparam logic [POS_W-1:0]   Center   = POS_W'(CenterI);
    localparam logic [FRAME_W-1:0] WidthRst = FRAME_W'(WidthCtr);

    logic [POS_W-1:0]        target_q, target_d;
    logic [POS_W-1:0]        cur_q, cur_d;
    logic [FRAME_W-1:0]      width_q, width_d;
    logic                    pwm_q, pwm_d;
    logic signed [DiffW-1:0] diff;
    logic [DiffW-1:0]        diff_mag;
    logic [ProdW-1:0]        prod;

    always_comb begin
        target_d = load_i ? pos_i : target_q;
    end

    always_comb begin
        diff     = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
        diff_mag = diff[DiffW-1] ? DiffW'(-diff) : DiffW'(diff);
        cur_d    = cur_q;
        if (boundary_i) begin
            if ((slew_step_i == '0) || (MagW'(diff_mag) <= MagW'(slew_step_i))) begin
                cur_d = target_q;
            end else if (diff[DiffW-1]) begin
                cur_d = cur_q - POS_W'(slew_step_i);
            end else begin
                cur_d = cur_q + POS_W'(slew_step_i);
            end
        end
    end

    // Width lags cur by one clock; the top guarantees this settles inside us 0.
    always_comb begin
        prod    = ProdW'(cur_q) * ProdW'(Span);
        width_d = FRAME_W'(MIN_US) + FRAME_W'(prod >> POS_W);
        pwm_d   = run_i && (frame_us_i < width_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= Center;
            cur_q    <= Center;
            width_q  <= WidthRst;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            width_q  <= width_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = (cur_q == target_q);

endmodule

// File: rtl/servo_pwm_multi.sv
// NUM_CH-channel RC-servo PWM generator: shared run state, microsecond
// prescaler and frame counter driving one servo_channel per output.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned POS_W     = 8,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned SLEW_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena_in,
    input  logic [NUM_CH*POS_W-1:0] pos_in,
    input  logic [NUM_CH-1:0]       pos_valid,
    input  logic [SLEW_W-1:0]       slew_step,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    frame_start,
    output logic [NUM_CH-1:0]       at_target
);

    localparam int unsigned TickDiv = tick_div(CLK_HZ);
    localparam int unsigned PresW   = bits_for(TickDiv);
    localparam int unsigned FrameW  = bits_for(PERIOD_US);

    localparam logic [PresW-1:0]  PresLast  = PresW'(TickDiv - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(PERIOD_US - 1);

    if (!((MIN_US < MAX_US) && (MAX_US < PERIOD_US))) begin : g_bad_range
        $error("servo_pwm_multi: need MIN_US < MAX_US < PERIOD_US");
    end
    if ((CLK_HZ % UsPerSec) != 0) begin : g_bad_clk
        $error("servo_pwm_multi: CLK_HZ must be a whole number of MHz");
    end
    if (TickDiv < 3) begin : g_bad_div
        $error("servo_pwm_multi: TICK_DIV must be at least 3");
    end

    state_e            state_q, state_d;
    logic [PresW-1:0]  presc_q, presc_d;
    logic [FrameW-1:0] frame_us_q, frame_us_d;
    logic              frame_start_q;
    logic              running;
    logic              us_tick;
    logic              frame_wrap;
    logic              boundary;

    // Counting only while enabled makes a drop of ena_in silence outputs on the next edge.
    assign running    = (state_q == StRun) && ena_in;
    assign us_tick    = running && (presc_q == PresLast);
    assign frame_wrap = us_tick && (frame_us_q == FrameLast);
    assign boundary   = ena_in && ((state_q == StIdle) || frame_wrap);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ena_in) state_d = StRun;
            StRun:   if (!ena_in) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        presc_d    = presc_q;
        frame_us_d = frame_us_q;
        if (!running || boundary) begin
            presc_d    = '0;
            frame_us_d = '0;
        end else if (us_tick) begin
            presc_d    = '0;
            frame_us_d = frame_us_q + FrameW'(1);
        end else begin
            presc_d = presc_q + PresW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            presc_q       <= '0;
            frame_us_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            frame_us_q    <= frame_us_d;
            frame_start_q <= boundary;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .POS_W  (POS_W),
            .SLEW_W (SLEW_W),
            .FRAME_W(FrameW),
            .MIN_US (MIN_US),
            .MAX_US (MAX_US)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .boundary_i (boundary),
            .run_i      (running),
            .frame_us_i (frame_us_q),
            .slew_step_i(slew_step),
            .pos_i      (pos_in[i*POS_W +: POS_W]),
            .load_i     (pos_valid[i]),
            .pwm_o      (pwm_out[i]),
            .at_target_o(at_target[i])
        );
    end

endmodule
